// File: rtl/event_timestamper_pkg.sv
// Shared types and reset constants for the event timestamper: the result
// record layout and default widths used by the top, the interface and benches.
package event_timestamper_pkg;

  localparam int ID_W_DEF = 3;
  localparam int TS_W_DEF = 8;

  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [TS_W_DEF-1:0] start_ts;
    logic [TS_W_DEF-1:0] end_ts;
    logic [TS_W_DEF-1:0] delta;
  } rec_t;

  localparam int CNT_RST    = 0;
  localparam bit VLD_RST    = 1'b0;
  localparam bit ACTIVE_RST = 1'b0;

endpackage

// File: rtl/event_timestamper_if.sv
// START/END event handshakes and the result record stream of the timestamper.
// master = producers/consumer side, slave = the timestamper itself.
interface event_timestamper_if
  import event_timestamper_pkg::*;
#(
  parameter int ID_W = ID_W_DEF,
  parameter int TS_W = TS_W_DEF
);
  logic            start_valid;
  logic            start_ready;
  logic [ID_W-1:0] start_id;
  logic            end_valid;
  logic            end_ready;
  logic [ID_W-1:0] end_id;
  logic            out_valid;
  logic            out_ready;
  logic [ID_W-1:0] out_id;
  logic [TS_W-1:0] out_start_ts;
  logic [TS_W-1:0] out_end_ts;
  logic [TS_W-1:0] out_delta;

  modport master (
    output start_valid, start_id, end_valid, end_id, out_ready,
    input  start_ready, end_ready, out_valid, out_id, out_start_ts, out_end_ts, out_delta
  );

  modport slave (
    input  start_valid, start_id, end_valid, end_id, out_ready,
    output start_ready, end_ready, out_valid, out_id, out_start_ts, out_end_ts, out_delta
  );
endinterface

// File: rtl/event_timestamper_scoreboard.sv
// Per-ID scoreboard: active bit vector plus start-timestamp RAM, with a
// write port for START, a read/clear port for END and an active lookup.
module ts_scoreboard
  import event_timestamper_pkg::*;
#(
  parameter int ID_W = ID_W_DEF,
  parameter int TS_W = TS_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [ID_W-1:0] wr_id,
  input  logic [TS_W-1:0] wr_ts,
  input  logic [ID_W-1:0] chk_id,
  output logic            chk_active,
  input  logic            clr_en,
  input  logic [ID_W-1:0] rd_id,
  output logic            rd_active,
  output logic [TS_W-1:0] rd_ts
);
  localparam int DEPTH = 1 << ID_W;

  logic [DEPTH-1:0] active_q;
  logic [TS_W-1:0]  ts_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= {DEPTH{ACTIVE_RST}};
    end else begin
      if (clr_en) active_q[rd_id] <= 1'b0;
      if (wr_en)  active_q[wr_id] <= 1'b1;
    end
  end

  // Timestamps are only meaningful while the matching active bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_id] <= wr_ts;
  end

  assign chk_active = active_q[chk_id];
  assign rd_active  = active_q[rd_id];
  assign rd_ts      = ts_mem[rd_id];
endmodule

// File: rtl/event_timestamper.sv
// Cycle-latency timestamper: free-running counter, per-ID scoreboard and a
// one-deep result register. Optional stray-END counter: EVENT_TIMESTAMPER_STRAY_CNT_EN.
module event_timestamper
  import event_timestamper_pkg::*;
#(
  parameter int ID_W = ID_W_DEF,
  parameter int TS_W = TS_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  event_timestamper_if.slave  bus
`ifdef EVENT_TIMESTAMPER_STRAY_CNT_EN
  ,
  output logic [15:0]         stray_cnt
`endif
);
  function automatic logic [TS_W-1:0] ts_wrap_sub(input logic [TS_W-1:0] a,
                                                  input logic [TS_W-1:0] b);
    return a - b;
  endfunction

  logic [TS_W-1:0] cnt_q;
  logic            start_ready, end_ready;
  logic            start_fire, end_fire, end_hit;
  logic            sb_start_active, sb_end_active;
  logic [TS_W-1:0] sb_start_ts;

  logic            vld_p1;
  logic [ID_W-1:0] out_id_p1;
  logic [TS_W-1:0] out_start_p1, out_end_p1, out_delta_p1;

  // END wins over a same-ID START in the same cycle.
  assign end_ready   = !vld_p1 || bus.out_ready;
  assign end_fire    = bus.end_valid && end_ready;
  assign end_hit     = end_fire && sb_end_active;
  assign start_ready = !sb_start_active && !(end_fire && (bus.end_id == bus.start_id));
  assign start_fire  = bus.start_valid && start_ready;

  ts_scoreboard #(.ID_W(ID_W), .TS_W(TS_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (start_fire),
    .wr_id      (bus.start_id),
    .wr_ts      (cnt_q),
    .chk_id     (bus.start_id),
    .chk_active (sb_start_active),
    .clr_en     (end_hit),
    .rd_id      (bus.end_id),
    .rd_active  (sb_end_active),
    .rd_ts      (sb_start_ts)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= TS_W'(CNT_RST);
    else     cnt_q <= cnt_q + TS_W'(1);
  end

  // Stage p1: result register, loaded on a matched END, held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= VLD_RST;
      out_id_p1    <= '0;
      out_start_p1 <= '0;
      out_end_p1   <= '0;
      out_delta_p1 <= '0;
    end else if (end_hit) begin
      vld_p1       <= 1'b1;
      out_id_p1    <= bus.end_id;
      out_start_p1 <= sb_start_ts;
      out_end_p1   <= cnt_q;
      out_delta_p1 <= ts_wrap_sub(cnt_q, sb_start_ts);
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1       <= 1'b0;
    end
  end

  assign bus.start_ready  = start_ready;
  assign bus.end_ready    = end_ready;
  assign bus.out_valid    = vld_p1;
  assign bus.out_id       = out_id_p1;
  assign bus.out_start_ts = out_start_p1;
  assign bus.out_end_ts   = out_end_p1;
  assign bus.out_delta    = out_delta_p1;

`ifdef EVENT_TIMESTAMPER_STRAY_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stray_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            stray_q <= '0;
    else if (end_fire && !sb_end_active) stray_q <= sat_inc16(stray_q);
  end

  assign stray_cnt = stray_q;
`endif
endmodule

// File: tb/tb_event_timestamper.sv
// Bench for event_timestamper: directed event sequences, a time/ID-map model
// compared every cycle, and literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_event_timestamper;
  import event_timestamper_pkg::*;

  localparam int ID_W = 3;
  localparam int TS_W = 8;
  localparam int MOD  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  event_timestamper_if #(.ID_W(ID_W), .TS_W(TS_W)) bus();
`ifdef EVENT_TIMESTAMPER_STRAY_CNT_EN
  logic [15:0] stray_cnt;
`endif

  event_timestamper #(.ID_W(ID_W), .TS_W(TS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef EVENT_TIMESTAMPER_STRAY_CNT_EN
    ,
    .stray_cnt (stray_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: elapsed cycles since reset, a map of open IDs to their start
  // times, and the record the consumer should currently see.
  int t = 0;
  bit m_active [8];
  int m_start  [8];
  bit m_vld = 0;
  int m_id = 0, m_s = 0, m_e = 0, m_d = 0;
  int m_stray = 0;

  function automatic bit exp_end_ready();
    return !m_vld || bus.out_ready;
  endfunction

  function automatic bit exp_start_ready();
    return !m_active[bus.start_id] &&
           !(bus.end_valid && exp_end_ready() && bus.end_id == bus.start_id);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; m_vld = 0; m_id = 0; m_s = 0; m_e = 0; m_d = 0; m_stray = 0;
      for (int i = 0; i < 8; i++) begin m_active[i] = 0; m_start[i] = 0; end
    end else begin
      bit ef, sf;
      ef = bus.end_valid && exp_end_ready();
      sf = bus.start_valid && exp_start_ready();
      if (m_vld && bus.out_ready) m_vld = 0;
      if (ef) begin
        if (m_active[bus.end_id]) begin
          m_active[bus.end_id] = 0;
          m_vld = 1;
          m_id  = bus.end_id;
          m_s   = m_start[bus.end_id];
          m_e   = t % MOD;
          m_d   = (m_e - m_s + MOD) % MOD;
        end else if (m_stray < 65535) begin
          m_stray++;
        end
      end
      if (sf) begin
        m_active[bus.start_id] = 1;
        m_start[bus.start_id]  = t % MOD;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    chk("cnt_q",       dut.cnt_q,       t % MOD);
    chk("end_ready",   bus.end_ready,   exp_end_ready());
    chk("start_ready", bus.start_ready, exp_start_ready());
    chk("out_valid",   bus.out_valid,   m_vld);
    if (m_vld) begin
      chk("out_id",       bus.out_id,       m_id);
      chk("out_start_ts", bus.out_start_ts, m_s);
      chk("out_end_ts",   bus.out_end_ts,   m_e);
      chk("out_delta",    bus.out_delta,    m_d);
    end
`ifdef EVENT_TIMESTAMPER_STRAY_CNT_EN
    chk("stray_cnt", stray_cnt, m_stray);
`endif
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_ev(input int id, output int ts);
    bit done = 0;
    ts = -1;
    bus.start_valid = 1'b1;
    bus.start_id    = id[ID_W-1:0];
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.start_ready) begin ts = int'(dut.cnt_q); done = 1; end
      tick();
    end
    bus.start_valid = 1'b0;
    if (!done) chk("start_timeout", 0, 1);
  endtask

  task automatic end_ev(input int id, output int ts);
    bit done = 0;
    ts = -1;
    bus.end_valid = 1'b1;
    bus.end_id    = id[ID_W-1:0];
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.end_ready) begin ts = int'(dut.cnt_q); done = 1; end
      tick();
    end
    bus.end_valid = 1'b0;
    if (!done) chk("end_timeout", 0, 1);
  endtask

  task automatic expect_rec(input string name, input int id, input int s, input int e, input int d);
    rec_t got;
    got = '{id: bus.out_id, start_ts: bus.out_start_ts, end_ts: bus.out_end_ts, delta: bus.out_delta};
    chk({name, "_valid"}, bus.out_valid,  1);
    chk({name, "_id"},    got.id,         id);
    chk({name, "_start"}, got.start_ts,   s % MOD);
    chk({name, "_end"},   got.end_ts,     e % MOD);
    chk({name, "_delta"}, got.delta,      d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, e, s0, s1, s2, a, r, x;
    bus.start_valid = 0; bus.start_id = '0;
    bus.end_valid   = 0; bus.end_id   = '0;
    bus.out_ready   = 1;

    // Reset state
    @(posedge clk); #1;
    chk("rst_out_valid", bus.out_valid,  0);
    chk("rst_cnt",       dut.cnt_q,      0);
    chk("rst_out_id",    bus.out_id,     0);
    chk("rst_out_delta", bus.out_delta,  0);
    chk("rst_end_ready", bus.end_ready,  1);
    #1 rst = 1'b0;
    tick();

    // Basic: END six cycles after START, then hold the consumer off
    start_ev(3, c);
    repeat (5) tick();
    end_ev(3, e);
    chk("basic_end_cap", e, (c + 6) % MOD);
    expect_rec("basic", 3, c, c + 6, 6);
    bus.out_ready = 0;
    bus.end_valid = 1; bus.end_id = 3'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_end_ready", bus.end_ready, 0);
      expect_rec("stall", 3, c, c + 6, 6);
      tick();
    end
    bus.end_valid = 0;
    bus.out_ready = 1;
    tick();
    chk("basic_popped", bus.out_valid, 0);

    // Out-of-order burst
    start_ev(0, s0);
    start_ev(1, s1);
    start_ev(2, s2);
    chk("burst_s1", s1, (s0 + 1) % MOD);
    chk("burst_s2", s2, (s0 + 2) % MOD);
    end_ev(1, e);
    expect_rec("burst1", 1, s0 + 1, s0 + 3, 2);
    end_ev(0, e);
    expect_rec("burst0", 0, s0, s0 + 4, 4);
    end_ev(2, e);
    expect_rec("burst2", 2, s0 + 2, s0 + 5, 3);
    tick();

    // Same-ID START/END collision
    start_ev(5, a);
    repeat (2) tick();
    bus.start_valid = 1; bus.start_id = 3'd5;
    bus.end_valid   = 1; bus.end_id   = 3'd5;
    @(negedge clk);
    chk("coll_start_ready", bus.start_ready, 0);
    chk("coll_end_ready",   bus.end_ready,   1);
    tick();
    bus.end_valid = 0;
    expect_rec("coll1", 5, a, a + 3, 3);
    start_ev(5, r);
    chk("coll_retry_ts", r, (a + 4) % MOD);
    repeat (3) tick();
    end_ev(5, e);
    expect_rec("coll2", 5, r, r + 4, 4);

    // Counter wrap
    for (int i = 0; i < 300 && dut.cnt_q != 8'd250; i++) tick();
    chk("wrap_align", dut.cnt_q, 250);
    start_ev(4, c);
    chk("wrap_start", c, 250);
    repeat (9) tick();
    end_ev(4, e);
    expect_rec("wrap", 4, 250, 4, 10);
    tick();

    // Stray END
`ifdef EVENT_TIMESTAMPER_STRAY_CNT_EN
    chk("stray_before", stray_cnt, 0);
`endif
    end_ev(7, e);
    chk("stray_no_out", bus.out_valid, 0);
`ifdef EVENT_TIMESTAMPER_STRAY_CNT_EN
    chk("stray_after", stray_cnt, 1);
`endif

    // Asynchronous reset mid-operation
    start_ev(2, x);
    start_ev(6, x);
    bus.out_ready = 0;
    end_ev(6, e);
    chk("pre_rst_valid", bus.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_id",    bus.out_id,    0);
    chk("arst_out_delta", bus.out_delta, 0);
    chk("arst_cnt",       dut.cnt_q,     0);
    @(posedge clk); #2 rst = 1'b0;
    tick();
    bus.out_ready = 1;
    end_ev(2, e);
    chk("arst_no_rec", bus.out_valid, 0);
    tick();
    chk("arst_no_rec2", bus.out_valid, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
